uart_key_frame_rx: RTL and testbench
====================================

Name: uart_key_frame_rx

Overview:
- Receive-side counterpart of the board's key-state UART sender.
- Consumes byte strobes from the UART byte receiver (read_data / read_done) and reassembles framed 40-bit key_down vectors.
- Checks each frame and presents the last good vector, a one-cycle valid pulse, an error counter and a debug state nibble for the seven-segment digits.
- Used for board-to-board key mirroring and loopback checking of the PC link.

Parameters:
- HEADER, 8'hA5, frame start byte.
- NBYTES, 5, payload bytes per frame; payload width is 8*NBYTES = 40.
- TIMEOUT, 24'd1000000, maximum clk cycles allowed between bytes inside a frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- byte_valid  input  1  one-cycle strobe: a received byte is present on byte_data.
- byte_data  input  8  received byte, sampled only when byte_valid=1.
- key_data  output  40  last frame that passed the checksum; byte 0 maps to bits [7:0].
- frame_valid  output  1  one-cycle pulse when key_data updates.
- err_cnt  output  8  saturating count of checksum failures plus timeouts.
- sta  output  4  current state encoding, for debug.

Behaviour:
- Interface (decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values: key_data=0, frame_valid=0, err_cnt=0, sta=0 (IDLE). Internal shadow register, byte counter, running checksum and gap counter are all cleared.
- Frame format: HEADER, then NBYTES payload bytes (LSB byte first), then CHK. CHK = XOR of the payload bytes.
- States and sta encoding: IDLE=0, DATA=1, CHK=2.
- IDLE:
  - byte_valid with byte_data==HEADER -> DATA; clear counter, checksum and gap counter.
  - Any other byte is ignored; no error is counted.
- DATA:
  - On byte_valid, write byte_data into shadow[8*cnt +: 8] and XOR it into the checksum; cnt++.
  - When the written byte was at cnt==NBYTES-1 -> CHK.
  - A byte equal to HEADER is treated as payload; there is no resync.
- CHK, on byte_valid:
  - byte_data==checksum: key_data<=shadow, frame_valid=1 on the next cycle, -> IDLE.
  - Mismatch: err_cnt increments, key_data is unchanged, -> IDLE.
- Latency: key_data and frame_valid update together on the clk edge that samples the CHK byte strobe. They are visible in the cycle after the strobe. frame_valid lasts exactly one cycle.
- Gap timeout:
  - In DATA or CHK, the gap counter increments every cycle without byte_valid and clears on byte_valid.
  - When it reaches TIMEOUT without a byte: -> IDLE, err_cnt increments, shadow is discarded.
  - If byte_valid arrives in the same cycle the counter reaches TIMEOUT, the byte wins and no timeout occurs.
  - The gap counter is inactive in IDLE.
- err_cnt saturates at 255; it wraps never. It is cleared only by rst.
- Back-to-back operation: a HEADER strobe arriving the cycle after the CHK byte is accepted. The frame_valid pulse of the previous frame does not block it.
- rst asserted mid-frame: partial frame discarded, all outputs at reset values the next cycle.
- Consecutive byte_valid pulses are legal; every strobe is processed.
- Implementation estimate: about 150–200 RTL lines.

Test Plan:
- Good frame: bytes A5,01,02,04,08,10,CHK=1F -> one-cycle frame_valid one cycle after the 1F strobe; key_data=40'h10_08_04_02_01; err_cnt=0.
- Bad checksum: A5,FF,00,00,00,00,00 -> no frame_valid; key_data keeps its prior value; err_cnt=1; sta returns to 0.
- Garbage, then timeout:
  - 3C,77 then a good frame -> only the good frame is accepted; err_cnt=0.
  - With TIMEOUT=16: A5,11 then 16 idle cycles -> sta=0, err_cnt=1.
  - A byte at idle cycle 16 exactly -> no timeout.
- Header inside payload and back-to-back:
  - A5,A5,00,00,00,00,A5 -> accepted; key_data=40'h00000000A5.
  - Immediately followed by a second valid frame -> two frame_valid pulses.
- Reset mid-frame: A5,01,02, rst high one cycle, then 00,00,00,00 -> nothing accepted. All outputs are zero after rst, and a subsequent full frame is accepted normally.
- Saturation: 300 bad-checksum frames -> err_cnt=255 and holds.

Source files
------------

// File: rtl/uart_key_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_key_frame_rx
// Description : Reassembles HEADER / payload / XOR-checksum frames from a UART
//               byte stream into a key_down vector, with gap timeout and a
//               saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_key_frame_rx #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int          NBYTES  = 5,
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic [8*NBYTES-1:0]   key_data,
    output logic                  frame_valid,
    output logic [7:0]            err_cnt,
    output logic [3:0]            sta
);

    localparam int          c_CW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(NBYTES - 1);
    localparam logic [23:0] c_GAP_LAST = TIMEOUT - 24'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CHK  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [8*NBYTES-1:0]   r_shadow;
    logic [8*NBYTES-1:0]   r_key;
    logic [c_CW-1:0]       r_cnt;
    logic [7:0]            r_chk;
    logic [23:0]           r_gap;
    logic [7:0]            r_err;
    logic                  r_frame_valid;
    logic                  w_accept;
    logic                  w_bad;
    logic                  w_timeout;
    logic                  w_gap_hit;
    logic                  w_hdr_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A strobe in the same cycle as the gap limit always takes priority.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_bad       = 1'b0;
        w_timeout   = 1'b0;
        w_hdr_start = 1'b0;
        w_gap_hit   = (r_gap == c_GAP_LAST);
        case (r_state)
            ST_IDLE: begin
                if (byte_valid && (byte_data == HEADER)) begin
                    w_hdr_start = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (byte_valid) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = ST_CHK;
                    end
                end else if (w_gap_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (byte_valid) begin
                    if (byte_data == r_chk) begin
                        w_accept = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end else if (w_gap_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow      <= '0;
            r_key         <= '0;
            r_cnt         <= '0;
            r_chk         <= '0;
            r_gap         <= '0;
            r_err         <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_accept;
            if (w_accept) begin
                r_key <= r_shadow;
            end
            if ((w_bad || w_timeout) && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end

            if ((r_state == ST_IDLE) || byte_valid) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + 24'd1;
            end

            if (w_hdr_start || w_timeout) begin
                r_shadow <= '0;
                r_cnt    <= '0;
                r_chk    <= '0;
            end else if ((r_state == ST_DATA) && byte_valid) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (r_cnt == c_CW'(i)) begin
                        r_shadow[8*i +: 8] <= byte_data;
                    end
                end
                r_chk <= r_chk ^ byte_data;
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    assign key_data    = r_key;
    assign frame_valid = r_frame_valid;
    assign err_cnt     = r_err;
    assign sta         = {2'b00, r_state};

endmodule
`default_nettype wire

// File: tb/tb_uart_key_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_key_frame_rx
// Description : Directed self-checking bench for uart_key_frame_rx with a
//               queue of expected key vectors popped on each frame_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_key_frame_rx;

    localparam logic [7:0]  c_HDR = 8'hA5;
    localparam int          c_NB  = 5;
    localparam logic [23:0] c_TO  = 24'd16;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [39:0] key_data;
    logic        frame_valid;
    logic [7:0]  err_cnt;
    logic [3:0]  sta;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [39:0] q_exp[$];
    logic [39:0] exp_key;
    int          exp_err;

    uart_key_frame_rx #(
        .HEADER  (c_HDR),
        .NBYTES  (c_NB),
        .TIMEOUT (c_TO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .key_data    (key_data),
        .frame_valid (frame_valid),
        .err_cnt     (err_cnt),
        .sta         (sta)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Every frame_valid pulse must match the oldest outstanding good frame.
    always @(negedge clk) begin
        logic [39:0] e;
        if (frame_valid === 1'b1) begin
            check("frame_expected", 64'(q_exp.size() > 0), 64'd1);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check("frame_key", 64'(key_data), 64'(e));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] xsum(input logic [39:0] p);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < c_NB; i++) x = x ^ p[8*i +: 8];
        return x;
    endfunction

    task automatic send_frame(input logic [39:0] p, input logic [7:0] chk);
        send(c_HDR);
        for (int i = 0; i < c_NB; i++) send(p[8*i +: 8]);
        if (chk == xsum(p)) begin
            q_exp.push_back(p);
            exp_key = p;
        end else if (exp_err < 255) begin
            exp_err = exp_err + 1;
        end
        send(chk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_key"}, 64'(key_data), 64'(exp_key));
        check({tag, "_err"}, 64'(err_cnt), 64'(exp_err));
        check({tag, "_sta"}, 64'(sta), 64'd0);
        check({tag, "_pending"}, 64'(q_exp.size()), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        exp_key    = '0;
        exp_err    = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_key", 64'(key_data), 64'd0);
        check("reset_fv", 64'(frame_valid), 64'd0);
        check("reset_err", 64'(err_cnt), 64'd0);
        check("reset_sta", 64'(sta), 64'd0);

        // Good frame, walking state and latency by hand
        send(c_HDR);
        check("good_sta_data", 64'(sta), 64'd1);
        send(8'h01); send(8'h02); send(8'h04); send(8'h08);
        check("good_sta_still_data", 64'(sta), 64'd1);
        send(8'h10);
        check("good_sta_chk", 64'(sta), 64'd2);
        check("good_no_early_fv", 64'(frame_valid), 64'd0);
        q_exp.push_back(40'h10_08_04_02_01);
        exp_key = 40'h10_08_04_02_01;
        send(8'h1F);
        check("good_fv_pulse", 64'(frame_valid), 64'd1);
        check("good_key_const", 64'(key_data), 64'h10_0804_0201);
        idle(1);
        check("good_fv_one_cycle", 64'(frame_valid), 64'd0);
        check_idle("good");

        // Bad checksum
        send_frame(40'h00_0000_00FF, 8'h00);
        idle(2);
        check("bad_err_one", 64'(err_cnt), 64'd1);
        check_idle("bad");

        // Garbage in IDLE is ignored
        send(8'h3C); send(8'h77);
        check("garbage_sta", 64'(sta), 64'd0);
        send_frame(40'h55_AA_33_CC_0F, xsum(40'h55_AA_33_CC_0F));
        idle(2);
        check_idle("garbage");

        // Timeout boundary: a byte on the 16th quiet cycle keeps the frame alive
        send(c_HDR); send(8'h11);
        idle(15);
        send(8'h22);
        check("gap_byte_wins_sta", 64'(sta), 64'd1);
        check("gap_byte_wins_err", 64'(err_cnt), 64'(exp_err));
        idle(15);
        check("gap_not_yet_sta", 64'(sta), 64'd1);
        idle(1);
        exp_err = exp_err + 1;
        check("gap_timeout_sta", 64'(sta), 64'd0);
        check_idle("timeout");

        // Header inside payload, then a back-to-back frame
        send_frame(40'h00_0000_00A5, 8'hA5);
        send_frame(40'hDE_AD_BE_EF_42, xsum(40'hDE_AD_BE_EF_42));
        idle(2);
        check_idle("b2b");

        // Reset in the middle of a frame
        send(c_HDR); send(8'h01); send(8'h02);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_key = '0;
        exp_err = 0;
        check("midrst_fv", 64'(frame_valid), 64'd0);
        check_idle("midrst");
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        idle(2);
        check_idle("midrst_tail");
        send_frame(40'h01_23_45_67_89, xsum(40'h01_23_45_67_89));
        idle(2);
        check_idle("midrst_after");

        // Saturation of the error counter
        for (int k = 0; k < 300; k++) send_frame(40'h00_0000_00FF, 8'h00);
        idle(2);
        check("sat_err_255", 64'(err_cnt), 64'd255);
        send_frame(40'h00_0000_0001, 8'h00);
        idle(2);
        check("sat_err_hold", 64'(err_cnt), 64'd255);
        send_frame(40'h80_40_20_10_08, xsum(40'h80_40_20_10_08));
        idle(2);
        check_idle("sat_good");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
